// File: rtl/mips_pkg.sv
// Shared widths, opcode/funct encodings, ALU control codes and the ID/EX payload record.
package mips_pkg;

  localparam int XLEN = 32;
  localparam int REGA = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0100,
    ALU_MULT = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SRL  = 4'b1001,
    ALU_SRA  = 4'b1010,
    ALU_DIV  = 4'b1011,
    ALU_NOR  = 4'b1100
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_op_e         ctrl;
    logic [REGA-1:0] dst;
    logic            we;
  } idex_t;

  localparam idex_t IDEX_RESET = '{a: '0, b: '0, ctrl: ALU_ADD, dst: '0, we: 1'b0};

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct decode into ALU control and operand/writeback steering flags.
// Zero latency; no handshake.
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output alu_op_e    o_alu_ctrl,
  output logic       o_is_shift,
  output logic       o_is_rtype,
  output logic       o_writes_reg
);

  always_comb begin
    o_alu_ctrl   = ALU_ADD;
    o_is_shift   = 1'b0;
    o_is_rtype   = (i_opcode == OP_RTYPE);
    o_writes_reg = !(i_opcode == OP_SW || i_opcode == OP_BEQ);
    if (o_is_rtype) begin
      case (i_funct)
        FN_AND:  o_alu_ctrl = ALU_AND;
        FN_OR:   o_alu_ctrl = ALU_OR;
        FN_ADD:  o_alu_ctrl = ALU_ADD;
        FN_SUB:  o_alu_ctrl = ALU_SUB;
        FN_MULT: o_alu_ctrl = ALU_MULT;
        FN_DIV:  o_alu_ctrl = ALU_DIV;
        FN_XOR:  o_alu_ctrl = ALU_XOR;
        FN_NOR:  o_alu_ctrl = ALU_NOR;
        FN_SLT:  o_alu_ctrl = ALU_SLT;
        FN_SLL:  begin o_alu_ctrl = ALU_SLL; o_is_shift = 1'b1; end
        FN_SRL:  begin o_alu_ctrl = ALU_SRL; o_is_shift = 1'b1; end
        FN_SRA:  begin o_alu_ctrl = ALU_SRA; o_is_shift = 1'b1; end
        default: o_alu_ctrl = ALU_ADD;
      endcase
    end else begin
      case (i_opcode)
        OP_ADDI, OP_LW, OP_SW: o_alu_ctrl = ALU_ADD;
        OP_ANDI:               o_alu_ctrl = ALU_AND;
        OP_ORI:                o_alu_ctrl = ALU_OR;
        OP_SLTI:               o_alu_ctrl = ALU_SLT;
        OP_BEQ:                o_alu_ctrl = ALU_SUB;
        default:               o_alu_ctrl = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: single entry, one-cycle latency, in_ready = !out_valid || out_ready.
// Operands resolved (bypass + $0 rule) at load and held through stalls; bypass enabled by ID_EX_FWD_EN.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      in_opcode,
  input  logic [5:0]      in_funct,
  input  logic [REGA-1:0] in_rs,
  input  logic [REGA-1:0] in_rt,
  input  logic [REGA-1:0] in_rd,
  input  logic [XLEN-1:0] in_rs_data,
  input  logic [XLEN-1:0] in_rt_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            fwd_ex_we,
  input  logic [REGA-1:0] fwd_ex_rd,
  input  logic [XLEN-1:0] fwd_ex_data,
  input  logic            fwd_wb_we,
  input  logic [REGA-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_alu_ctrl,
  output logic [REGA-1:0] out_dst,
  output logic            out_we
);

  logic            r_valid;
  idex_t           r_out;
  idex_t           w_next;
  alu_op_e         w_alu_ctrl;
  logic            w_is_shift;
  logic            w_is_rtype;
  logic            w_writes_reg;
  logic            w_load;
  logic [XLEN-1:0] w_rs_val;
  logic [XLEN-1:0] w_rt_val;

  alu_ctrl_decode u_dec (
    .i_opcode     (in_opcode),
    .i_funct      (in_funct),
    .o_alu_ctrl   (w_alu_ctrl),
    .o_is_shift   (w_is_shift),
    .o_is_rtype   (w_is_rtype),
    .o_writes_reg (w_writes_reg)
  );

  function automatic logic [XLEN-1:0] f_operand(input logic [REGA-1:0] src,
                                                input logic [XLEN-1:0] rf_data);
    logic [XLEN-1:0] v;
    v = rf_data;
`ifdef ID_EX_FWD_EN
    if (fwd_ex_we && fwd_ex_rd == src)      v = fwd_ex_data;
    else if (fwd_wb_we && fwd_wb_rd == src) v = fwd_wb_data;
`endif
    // $0 is hardwired: neither the register file nor a bypass may supply a value.
    if (src == '0) v = '0;
    return v;
  endfunction

`ifndef ID_EX_FWD_EN
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd_ex_we, fwd_ex_rd, fwd_ex_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data};
`endif

  assign w_rs_val = f_operand(in_rs, in_rs_data);
  assign w_rt_val = f_operand(in_rt, in_rt_data);
  assign in_ready = !r_valid || out_ready;
  assign w_load   = in_valid && in_ready;

  always_comb begin
    w_next      = IDEX_RESET;
    w_next.ctrl = w_alu_ctrl;
    w_next.dst  = w_is_rtype ? in_rd : in_rt;
    w_next.we   = w_writes_reg && (w_next.dst != '0);
    // Shifts take the shifted value from rt; shamt rides in the immediate.
    if (w_is_shift) begin
      w_next.a = w_rt_val;
      w_next.b = in_imm;
    end else if (w_is_rtype) begin
      w_next.a = w_rs_val;
      w_next.b = w_rt_val;
    end else begin
      w_next.a = w_rs_val;
      w_next.b = in_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_out   <= IDEX_RESET;
    end else if (flush) begin
      r_valid  <= 1'b0;
      r_out.we <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_out   <= w_next;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid    = r_valid;
  assign out_a        = r_out.a;
  assign out_b        = r_out.b;
  assign out_alu_ctrl = r_out.ctrl;
  assign out_dst      = r_out.dst;
  assign out_we       = r_out.we;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: transaction-level reference model plus directed literal cases and random traffic.
module tb_id_ex_stage;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  dst;
    logic        we;
  } exp_t;

  logic        clk, rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready, out_we;
  logic [5:0]  in_opcode, in_funct;
  logic [4:0]  in_rs, in_rt, in_rd, fwd_ex_rd, fwd_wb_rd, out_dst;
  logic [31:0] in_rs_data, in_rt_data, in_imm, fwd_ex_data, fwd_wb_data, out_a, out_b;
  logic        fwd_ex_we, fwd_wb_we;
  logic [3:0]  out_alu_ctrl;

  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_on = 0;
  logic m_valid;
  exp_t m_e;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .fwd_ex_we(fwd_ex_we), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_ctrl(out_alu_ctrl), .out_dst(out_dst), .out_we(out_we)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Value an instruction sees for a source register at the moment it is accepted.
  function automatic logic [31:0] src_val(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return 32'h0;
`ifdef ID_EX_FWD_EN
    if (fwd_ex_we && fwd_ex_rd == r) return fwd_ex_data;
    if (fwd_wb_we && fwd_wb_rd == r) return fwd_wb_data;
`endif
    return rf;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic rtype, shift;
    rtype  = (in_opcode == 6'h00);
    shift  = rtype && (in_funct inside {6'h00, 6'h02, 6'h03});
    e.ctrl = 4'b0010;
    if (rtype) begin
      case (in_funct)
        6'h24: e.ctrl = 4'b0000;  6'h25: e.ctrl = 4'b0001;
        6'h22: e.ctrl = 4'b0110;  6'h18: e.ctrl = 4'b0101;
        6'h1A: e.ctrl = 4'b1011;  6'h26: e.ctrl = 4'b0100;
        6'h27: e.ctrl = 4'b1100;  6'h2A: e.ctrl = 4'b0111;
        6'h00: e.ctrl = 4'b1000;  6'h02: e.ctrl = 4'b1001;
        6'h03: e.ctrl = 4'b1010;  default: e.ctrl = 4'b0010;
      endcase
    end else begin
      case (in_opcode)
        6'h0C: e.ctrl = 4'b0000;  6'h0D: e.ctrl = 4'b0001;
        6'h0A: e.ctrl = 4'b0111;  6'h04: e.ctrl = 4'b0110;
        default: e.ctrl = 4'b0010;
      endcase
    end
    e.a   = shift ? src_val(in_rt, in_rt_data) : src_val(in_rs, in_rs_data);
    e.b   = (shift || !rtype) ? in_imm : src_val(in_rt, in_rt_data);
    e.dst = rtype ? in_rd : in_rt;
    e.we  = (in_opcode != 6'h2B) && (in_opcode != 6'h04) && (e.dst != 0);
    return e;
  endfunction

  // Held instruction: present when accepted and not yet consumed; squashed by flush or reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_e     <= '{a: 0, b: 0, ctrl: 4'b0010, dst: 0, we: 0};
    end else begin
      bit accepted, consumed;
      accepted = in_valid && (!m_valid || out_ready);
      consumed = m_valid && out_ready;
      m_valid  <= !flush && (accepted || (m_valid && !consumed));
      if (flush) m_e.we <= 1'b0;
      else if (accepted) m_e <= predict();
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, !m_valid || out_ready});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      if (m_valid) begin
        chk("out_a", out_a, m_e.a);
        chk("out_b", out_b, m_e.b);
        chk("out_alu_ctrl", {28'b0, out_alu_ctrl}, {28'b0, m_e.ctrl});
        chk("out_dst", {27'b0, out_dst}, {27'b0, m_e.dst});
        chk("out_we", {31'b0, out_we}, {31'b0, m_e.we});
      end
    end
  end

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd,
                           input logic [31:0] rtd, input logic [31:0] imm);
    in_opcode = op; in_funct = fn; in_rs = rs; in_rt = rt; in_rd = rd;
    in_rs_data = rsd; in_rt_data = rtd; in_imm = imm;
  endtask

  task automatic no_fwd();
    fwd_ex_we = 0; fwd_ex_rd = 0; fwd_ex_data = 0;
    fwd_wb_we = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [10];
    logic [5:0] fns [13];
    logic [31:0] exp_fwd;
    ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h0C, 6'h0D, 6'h0A, 6'h04};
    fns = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h18, 6'h1A, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h3F};

    rst_n = 1; in_valid = 0; out_ready = 0; flush = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    no_fwd();
    #2 rst_n = 0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_we", {31'b0, out_we}, 32'd0);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_out_alu_ctrl", {28'b0, out_alu_ctrl}, 32'd2);
    chk("rst_out_dst", {27'b0, out_dst}, 32'd0);
    #19 rst_n = 1;
    chk_on = 1;

    // add $3,$1,$2
    out_ready = 1; in_valid = 1;
    set_instr(6'h00, 6'h20, 1, 2, 3, 5, 7, 0);
    step();
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_a", out_a, 32'd5);
    chk("add_b", out_b, 32'd7);
    chk("add_ctrl", {28'b0, out_alu_ctrl}, 32'b0010);
    chk("add_dst", {27'b0, out_dst}, 32'd3);
    chk("add_we", {31'b0, out_we}, 32'd1);

    // EX bypass beats WB bypass on the same register
    set_instr(6'h00, 6'h20, 4, 5, 6, 32'h11, 32'h22, 0);
    fwd_ex_we = 1; fwd_ex_rd = 4; fwd_ex_data = 32'hAA;
    fwd_wb_we = 1; fwd_wb_rd = 4; fwd_wb_data = 32'hBB;
`ifdef ID_EX_FWD_EN
    exp_fwd = 32'hAA;
`else
    exp_fwd = 32'h11;
`endif
    step();
    chk("fwd_prio_a", out_a, exp_fwd);

    // $0 is never bypassed
    set_instr(6'h00, 6'h20, 0, 5, 6, 32'h1234, 32'h22, 0);
    fwd_wb_we = 0; fwd_ex_rd = 0; fwd_ex_data = 9;
    step();
    chk("zero_reg_a", out_a, 32'd0);
    no_fwd();

    // sra: value from rt, shamt via immediate
    set_instr(6'h00, 6'h03, 1, 2, 3, 32'h5, 32'h80000000, 32'h100);
    step();
    chk("sra_a", out_a, 32'h80000000);
    chk("sra_b", out_b, 32'h100);
    chk("sra_ctrl", {28'b0, out_alu_ctrl}, 32'b1010);

    // sw never writes back
    set_instr(6'h2B, 6'h00, 1, 9, 0, 32'h40, 32'h0, 32'h8);
    step();
    chk("sw_we", {31'b0, out_we}, 32'd0);
    chk("sw_b", out_b, 32'h8);

    // stall: held instruction keeps values captured at load even as the bypass changes
    set_instr(6'h00, 6'h20, 4, 2, 7, 32'h11, 32'h3, 0);
    fwd_ex_we = 1; fwd_ex_rd = 4; fwd_ex_data = 32'hAA;
    step();
    set_instr(6'h08, 6'h00, 3, 8, 0, 32'h77, 32'h0, 32'h10);
    fwd_ex_data = 32'h55;
    out_ready = 0;
    #1;
    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_a", out_a, exp_fwd);
      chk("stall_hold_dst", {27'b0, out_dst}, 32'd7);
    end
    no_fwd();
    out_ready = 1;
    step();
    chk("resume_a", out_a, 32'h77);
    chk("resume_dst", {27'b0, out_dst}, 32'd8);

    // flush beats a simultaneous load
    set_instr(6'h00, 6'h20, 1, 2, 3, 5, 7, 0);
    flush = 1;
    #1;
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_we", {31'b0, out_we}, 32'd0);
    flush = 0;

    // reset pulse in the middle of a stall
    step();
    out_ready = 0;
    step();
    step();
    #2 rst_n = 0;
    #1;
    chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid_a", out_a, 32'd0);
    chk("rst_mid_ctrl", {28'b0, out_alu_ctrl}, 32'b0010);
    #3 rst_n = 1;
    out_ready = 1;
    set_instr(6'h0D, 6'h00, 2, 5, 0, 32'h99, 32'h0, 32'hF0);
    step();
    chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
    chk("post_rst_a", out_a, 32'h99);
    chk("post_rst_ctrl", {28'b0, out_alu_ctrl}, 32'b0001);

    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      set_instr(ops[$urandom_range(0, 9)], fns[$urandom_range(0, 12)],
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                $urandom, $urandom, $urandom);
      fwd_ex_we = 1'($urandom); fwd_ex_rd = 5'($urandom_range(0, 7)); fwd_ex_data = $urandom;
      fwd_wb_we = 1'($urandom); fwd_wb_rd = 5'($urandom_range(0, 7)); fwd_wb_data = $urandom;
      step();
    end

    in_valid = 0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 in_valid / in_ready  in / out  1 / 1  upstream (decode) handshake; transfer when both high.
REQ-005 in_opcode, in_funct  in  6, 6  instruction fields.
REQ-006 in_rs, in_rt, in_rd  in  5 each  register addresses.
REQ-007 in_rs_data, in_rt_data, in_imm  in  32 each  register-file reads and sign-extended immediate.
REQ-008 fwd_ex_we, fwd_ex_rd, fwd_ex_data  in  1, 5, 32  EX/MEM writeback bypass.
REQ-009 fwd_wb_we, fwd_wb_rd, fwd_wb_data  in  1, 5, 32  MEM/WB writeback bypass.
REQ-010 flush  in  1  synchronous squash of the held instruction (branch taken).
REQ-011 out_valid / out_ready  out / in  1 / 1  downstream (ALU stage) handshake.
REQ-012 out_a, out_b  out  32 each  ALU operands; out_alu_ctrl  out  4  ALU operation; out_dst  out  5  writeback register; out_we  out  1  writeback enable.

Function
REQ-013 Single-entry register stage: in_ready = !out_valid || out_ready (combinational); load on in_valid && in_ready.
REQ-014 Latency exactly one cycle from accepted input to out_valid; full throughput when out_ready held high.
REQ-015 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-016 Operand forwarding, per source (rs, rt) at load time: EX bypass if fwd_ex_we && fwd_ex_rd==src && src!=0; else WB bypass under same rule; else register-file data; EX has priority over WB.
REQ-017 Register $0 never forwarded; reads of $0 SHALL yield 0 regardless of in_*_data.
REQ-018 ALU control, R-type (opcode 0x00) by funct: 0x24 and=0000, 0x25 or=0001, 0x20 add=0010, 0x22 sub=0110, 0x18 mult=0101, 0x1A div=1011, 0x26 xor=0100, 0x27 nor=1100, 0x2A slt=0111, 0x00 sll=1000, 0x02 srl=1001, 0x03 sra=1010; other funct=0010.
REQ-019 I-type by opcode: 0x08 addi, 0x23 lw, 0x2B sw=0010; 0x0C andi=0000; 0x0D ori=0001; 0x0A slti=0111; 0x04 beq=0110; other=0010.
REQ-020 Operand select: shifts out_a=rt value, out_b=in_imm (shamt in bits 10:6); other R-type out_a=rs, out_b=rt; I-type out_a=rs, out_b=in_imm.
REQ-021 Destination: R-type out_dst=in_rd; I-type out_dst=in_rt; out_we=0 for sw, beq, and any dst of 0, else 1.
REQ-022 flush clears out_valid and out_we next edge; flush has priority over a simultaneous load (accepted input discarded, in_ready unaffected).
REQ-023 Stall (out_valid && !out_ready) SHALL NOT re-sample forwarding; forwarded values captured at load are retained.

Reset
REQ-024 On rst_n low: out_valid=0, out_we=0, out_a=0, out_b=0, out_alu_ctrl=0010, out_dst=0, immediately and independent of clk.
REQ-025 Reset mid-transfer SHALL drop the held instruction; first acceptance allowed on first edge after rst_n high.

Configuration
REQ-026 Macro ID_EX_FWD_EN: defined, REQ-016 forwarding active; undefined, operands taken only from in_*_data (still with $0 rule) and fwd_* inputs ignored.

Structure
REQ-027 Package mips_pkg SHALL hold ALU control codes, opcode/funct constants, and widths (XLEN=32, REGA=5).
REQ-028 Sub-module alu_ctrl_decode (combinational opcode/funct -> alu_ctrl, is_shift, is_rtype, writes_reg).

Verification
REQ-029 add $3,$1,$2 rs_data=5, rt_data=7, no bypass -> next cycle out_valid=1, out_a=5, out_b=7, ctrl=0010, dst=3, we=1.
REQ-030 rs=4, fwd_ex_we=1 rd=4 data=0xAA, fwd_wb_we=1 rd=4 data=0xBB -> out_a=0xAA; without ID_EX_FWD_EN out_a=rs_data.
REQ-031 rs=0, rs_data=0x1234, fwd_ex rd=0 data=9 -> out_a=0.
REQ-032 sra funct 0x03, rt_data=0x80000000, imm=0x00000100 -> out_a=0x80000000, out_b=0x100, ctrl=1010.
REQ-033 out_ready=0 three cycles with in_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> next instruction loads one cycle later.
REQ-034 flush asserted with in_valid=1 and in_ready=1 -> next cycle out_valid=0, out_we=0; rst_n pulse low mid-stall -> out_valid=0 immediately.
